lmdpl_dr_decoder: RTL

- Receive end of the LMDPL dual-rail precharge domain: sequences precharge/evaluate phases for an upstream LMDPL gadget network.
- Collapses the settled true/false rails back into a single-rail masked value and hands it out over a valid/ready port.
- Flags rail faults (double-high, stuck, incomplete). Placed at the output boundary of a masked LMDPL datapath, feeding conventional masked registers.

---
 rtl/lmdpl_pkg.sv | 24 ++
 rtl/lmdpl_rail_check.sv | 16 +
 rtl/lmdpl_dr_decoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lmdpl_pkg.sv
// Shared types for the LMDPL dual-rail receive decoder: FSM states, debug fault codes, default width.
package lmdpl_pkg;

    localparam int LMDPL_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        EVAL,
        HOLD
    } lmdpl_state_e;

    typedef enum logic [1:0] {
        NONE,
        PRE_FAULT,
        DOUBLE_HIGH,
        TIMEOUT
    } lmdpl_fault_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lmdpl_rail_check.sv
// Combinational rail-state summary for WIDTH dual-rail pairs: precharged, fully resolved, or double-high.
module lmdpl_rail_check #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] dr_t,
    input  logic [WIDTH-1:0] dr_f,
    output logic             all_zero,
    output logic             all_complete,
    output logic             any_double
);

    assign all_zero     = ~|(dr_t | dr_f);
    assign all_complete = &(dr_t ^ dr_f);
    assign any_double   = |(dr_t & dr_f);

endmodule

// File: rtl/lmdpl_dr_decoder.sv
// LMDPL receive end: sequences precharge/evaluate, collapses settled rails to single-rail data on a
// valid/ready port and flags rail faults. Define LMDPL_DEC_REMASK_EN to XOR an m_in mask into the capture.
//
// state | meaning
// IDLE  | network precharged, waiting for start
// PRE   | precharge held for PRE_CYCLES, rails must read all-zero on the last cycle
// EVAL  | evaluate, wait for every pair to resolve or EVAL_MAX cycles to pass
// HOLD  | decoded word offered downstream, network already re-precharging
module lmdpl_dr_decoder
    import lmdpl_pkg::*;
#(
    parameter int WIDTH      = LMDPL_WIDTH_DEF,
    parameter int PRE_CYCLES = 1,
    parameter int EVAL_MAX   = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic             start,
    output logic             pre,
    input  logic [WIDTH-1:0] dr_t,
    input  logic [WIDTH-1:0] dr_f,
`ifdef LMDPL_DEC_REMASK_EN
    input  logic [WIDTH-1:0] m_in,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(max_int(PRE_CYCLES, EVAL_MAX)) + 1;
    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_MAX - 1);

    lmdpl_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             all_zero;
    logic             all_complete;
    logic             any_double;
    logic             eval_done;
    lmdpl_fault_e     fault;
    logic [WIDTH-1:0] cap_data;

    lmdpl_rail_check #(
        .WIDTH(WIDTH)
    ) u_rail_check (
        .dr_t        (dr_t),
        .dr_f        (dr_f),
        .all_zero    (all_zero),
        .all_complete(all_complete),
        .any_double  (any_double)
    );

`ifdef LMDPL_DEC_REMASK_EN
    assign cap_data = dr_t ^ m_in;
`else
    assign cap_data = dr_t;
`endif

    assign cnt_zero  = (cnt == '0);
    assign eval_done = any_double | all_complete | cnt_zero;

    // Double-high wins over timeout when both occur on the final evaluate cycle.
    always_comb begin
        fault = NONE;
        case (state)
            PRE: begin
                if (cnt_zero && !all_zero) fault = PRE_FAULT;
            end
            EVAL: begin
                if (any_double)                    fault = DOUBLE_HIGH;
                else if (!all_complete && cnt_zero) fault = TIMEOUT;
            end
            default: fault = NONE;
        endcase
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state     <= IDLE;
            cnt       <= '0;
            pre       <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (fault != NONE) err <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PRE;
                        cnt   <= PRE_LOAD;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                    end
                end
                PRE: begin
                    if (cnt_zero) begin
                        state <= EVAL;
                        cnt   <= EVAL_LOAD;
                        pre   <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                EVAL: begin
                    if (eval_done) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        out_data  <= cap_data;
                        out_valid <= 1'b1;
                        pre       <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pre       <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
